voice_allocator: RTL

//  Polyphony scheduler: shares NUM_VOICES oscillator instances between incoming key on/off events.

---
 rtl/voice_allocator_pkg.sv | 19 +
 rtl/voice_slot.sv | 71 +++++++
 rtl/voice_allocator.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared types and default geometry for the polyphony voice allocator.
// Defaults size a 4-voice bank over a 52-key range.
package voice_allocator_pkg;

    localparam int NUM_VOICES_DEF = 4;
    localparam int KEY_W_DEF      = 7;
    localparam int KEY_MIN_DEF    = 25;
    localparam int KEY_MAX_DEF    = 76;
    localparam int AGE_W_DEF      = 8;

    typedef logic [KEY_W_DEF-1:0] key_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/voice_slot.sv
// One oscillator voice: key/gate/age registers plus the retrigger pulse flop.
// Clear beats load, load beats release, release beats ageing.
module voice_slot
    import voice_allocator_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int AGE_W = AGE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             rel,
    input  logic             age_inc,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key,
    output logic             gate,
    output logic [AGE_W-1:0] age,
    output logic             gate_nxt,
    output logic             retrig
);

    logic [KEY_W-1:0] key_q, key_d;
    logic             gate_q, gate_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             retrig_q, retrig_d;

    always_comb begin
        key_d    = key_q;
        gate_d   = gate_q;
        age_d    = age_q;
        retrig_d = 1'b0;
        if (clr) begin
            key_d  = '0;
            gate_d = 1'b0;
            age_d  = '0;
        end else if (load) begin
            key_d    = key_in;
            gate_d   = 1'b1;
            age_d    = '0;
            retrig_d = 1'b1;
        end else if (rel) begin
            key_d  = '0;
            gate_d = 1'b0;
            age_d  = '0;
        end else if (age_inc && gate_q && (age_q != '1)) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= '0;
            gate_q   <= 1'b0;
            age_q    <= '0;
            retrig_q <= 1'b0;
        end else begin
            key_q    <= key_d;
            gate_q   <= gate_d;
            age_q    <= age_d;
            retrig_q <= retrig_d;
        end
    end

    assign key      = key_q;
    assign gate     = gate_q;
    assign age      = age_q;
    assign gate_nxt = gate_d;
    assign retrig   = retrig_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: scans voices one per cycle, then commits a note-on/off in one cycle.
// Accept-to-output latency NUM_VOICES+2 cycles; ev_ready only in IDLE, all_off overrides everything.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int KEY_W      = KEY_W_DEF,
    parameter int KEY_MIN    = KEY_MIN_DEF,
    parameter int KEY_MAX    = KEY_MAX_DEF,
    parameter int AGE_W      = AGE_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic                        ev_on,
    input  logic [KEY_W-1:0]            ev_key,
    input  logic                        all_off,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]       voice_gate,
    output logic [NUM_VOICES-1:0]       voice_retrig,
    output logic                        stolen,
    output logic                        err_drop,
    output logic [3:0]                  active_cnt
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ev_on_q, ev_on_d;
    logic [KEY_W-1:0] ev_key_q, ev_key_d;
    logic             match_vld_q, match_vld_d;
    logic [IDX_W-1:0] match_idx_q, match_idx_d;
    logic             free_vld_q, free_vld_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic             old_vld_q, old_vld_d;
    logic [IDX_W-1:0] old_idx_q, old_idx_d;
    logic [AGE_W-1:0] old_age_q, old_age_d;
    logic             stolen_q, stolen_d;
    logic             err_drop_q, err_drop_d;
    logic [3:0]       cnt_q, cnt_d;

    logic [KEY_W-1:0]      key_arr [NUM_VOICES];
    logic [AGE_W-1:0]      age_arr [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_vec, gate_nxt, load_vec, rel_vec;
    logic                  age_inc;
    logic [IDX_W-1:0]      tgt;
    logic                  in_range;

    assign ev_ready = (state_q == ST_IDLE);
    assign in_range = (ev_key_q >= KEY_W'(KEY_MIN)) && (ev_key_q <= KEY_W'(KEY_MAX));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ev_on_d     = ev_on_q;
        ev_key_d    = ev_key_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        old_vld_d   = old_vld_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        stolen_d    = 1'b0;
        err_drop_d  = 1'b0;
        load_vec    = '0;
        rel_vec     = '0;
        age_inc     = 1'b0;
        tgt         = '0;

        case (state_q)
            ST_IDLE: begin
                if (ev_valid) begin
                    ev_on_d     = ev_on;
                    ev_key_d    = ev_key;
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    old_vld_d   = 1'b0;
                    idx_d       = '0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (gate_vec[idx_q] && (key_arr[idx_q] == ev_key_q) && !match_vld_q) begin
                    match_vld_d = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!gate_vec[idx_q] && !free_vld_q) begin
                    free_vld_d = 1'b1;
                    free_idx_d = idx_q;
                end
                // Strict greater-than keeps the lowest index on equal ages.
                if (gate_vec[idx_q] && (!old_vld_q || (age_arr[idx_q] > old_age_q))) begin
                    old_vld_d = 1'b1;
                    old_idx_d = idx_q;
                    old_age_d = age_arr[idx_q];
                end
                if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (ev_on_q) begin
                    if (!in_range) begin
                        err_drop_d = 1'b1;
                    end else begin
                        if (match_vld_q) begin
                            tgt = match_idx_q;
                        end else if (free_vld_q) begin
                            tgt = free_idx_q;
                        end else begin
                            tgt      = old_idx_q;
                            stolen_d = 1'b1;
                        end
                        load_vec[tgt] = 1'b1;
                        age_inc       = 1'b1;
                    end
                end else if (match_vld_q) begin
                    rel_vec[match_idx_q] = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (all_off) begin
            state_d    = ST_IDLE;
            stolen_d   = 1'b0;
            err_drop_d = 1'b0;
            load_vec   = '0;
            rel_vec    = '0;
            age_inc    = 1'b0;
        end

        // Count from next-state gates so the count lands with voice_gate.
        cnt_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            cnt_d = cnt_d + {3'b000, gate_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            ev_on_q     <= 1'b0;
            ev_key_q    <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            old_vld_q   <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            stolen_q    <= 1'b0;
            err_drop_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ev_on_q     <= ev_on_d;
            ev_key_q    <= ev_key_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            old_vld_q   <= old_vld_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            stolen_q    <= stolen_d;
            err_drop_q  <= err_drop_d;
            cnt_q       <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        voice_slot #(
            .KEY_W (KEY_W),
            .AGE_W (AGE_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (all_off),
            .load     (load_vec[i]),
            .rel      (rel_vec[i]),
            .age_inc  (age_inc),
            .key_in   (ev_key_q),
            .key      (key_arr[i]),
            .gate     (gate_vec[i]),
            .age      (age_arr[i]),
            .gate_nxt (gate_nxt[i]),
            .retrig   (voice_retrig[i])
        );
        assign voice_key[i*KEY_W +: KEY_W] = key_arr[i];
    end

    assign voice_gate = gate_vec;
    assign stolen     = stolen_q;
    assign err_drop   = err_drop_q;
    assign active_cnt = cnt_q;

endmodule
